// File: rtl/enigma_pkg.sv
// Shared types, widths and position helpers for the Enigma rotor scheduler.
package enigma_pkg;

  localparam int unsigned LETTER_W    = 5;
  localparam int unsigned NUM_LETTERS = 26;

  typedef enum logic [3:0] {
    IDLE,
    STEP,
    F1,
    F2,
    F3,
    RF,
    B3,
    B2,
    B1,
    HOLD
  } state_t;

  localparam logic [1:0] SEL_R1   = 2'd0;
  localparam logic [1:0] SEL_R2   = 2'd1;
  localparam logic [1:0] SEL_R3   = 2'd2;
  localparam logic [1:0] SEL_REFL = 2'd3;

  localparam logic [LETTER_W-1:0] POS_MAX = LETTER_W'(NUM_LETTERS - 1);

  // Advance one rotor position, wrapping 25 -> 0.
  function automatic logic [LETTER_W-1:0] pos_inc(input logic [LETTER_W-1:0] p);
    return (p == POS_MAX) ? '0 : p + LETTER_W'(1);
  endfunction

  // Fold a 5-bit configuration value into 0..25.
  function automatic logic [LETTER_W-1:0] pos_norm(input logic [LETTER_W-1:0] v);
    return (v > POS_MAX) ? v - LETTER_W'(NUM_LETTERS) : v;
  endfunction

endpackage

// File: rtl/enigma_rotor_stepper.sv
// Combinational rotor stepping: next positions and notch flags from the
// current (pre-step) positions, all three compares taken simultaneously.
module enigma_rotor_stepper
  import enigma_pkg::*;
#(
  parameter logic [LETTER_W-1:0] NOTCH1 = 5'd16,
  parameter logic [LETTER_W-1:0] NOTCH2 = 5'd4,
  parameter logic [LETTER_W-1:0] NOTCH3 = 5'd21
) (
  input  logic [LETTER_W-1:0] i_pos1,
  input  logic [LETTER_W-1:0] i_pos2,
  input  logic [LETTER_W-1:0] i_pos3,
  output logic [LETTER_W-1:0] o_next1,
  output logic [LETTER_W-1:0] o_next2,
  output logic [LETTER_W-1:0] o_next3,
  output logic                o_at_notch1,
  output logic                o_at_notch2,
  output logic                o_at_notch3
);

  assign o_at_notch1 = (i_pos1 == NOTCH1);
  assign o_at_notch2 = (i_pos2 == NOTCH2);
  assign o_at_notch3 = (i_pos3 == NOTCH3);

  // R2 steps on R1 carry or on its own notch (double step); R3 follows R2's notch.
  assign o_next1 = pos_inc(i_pos1);
  assign o_next2 = (o_at_notch1 || o_at_notch2) ? pos_inc(i_pos2) : i_pos2;
  assign o_next3 = o_at_notch2 ? pos_inc(i_pos3) : i_pos3;

endmodule

// File: rtl/enigma_rotor_sched.sv
// Enigma keypress sequencer: steps the rotors on each accepted key, then walks
// one shared substitution datapath through R1 R2 R3 REFL R3 R2 R1 and holds
// the resulting cipher letter until the consumer takes it.
module enigma_rotor_sched
  import enigma_pkg::*;
#(
  parameter logic [LETTER_W-1:0] NOTCH1 = 5'd16,
  parameter logic [LETTER_W-1:0] NOTCH2 = 5'd4,
  parameter logic [LETTER_W-1:0] NOTCH3 = 5'd21
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [LETTER_W-1:0] cfg_pos1,
  input  logic [LETTER_W-1:0] cfg_pos2,
  input  logic [LETTER_W-1:0] cfg_pos3,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [LETTER_W-1:0] key_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LETTER_W-1:0] out_letter,
  output logic                err,
  output logic [LETTER_W-1:0] pos1,
  output logic [LETTER_W-1:0] pos2,
  output logic [LETTER_W-1:0] pos3,
  output logic                at_notch3,
  output logic [1:0]          path_sel,
  output logic                path_dir,
  output logic [LETTER_W-1:0] path_rot,
  output logic [LETTER_W-1:0] path_in,
  input  logic [LETTER_W-1:0] path_out
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LETTER_W-1:0] r_pos1, r_pos2, r_pos3;
  logic [LETTER_W-1:0] r_letter;
  logic [LETTER_W-1:0] r_out;
  logic                r_err;

  logic [LETTER_W-1:0] w_next1, w_next2, w_next3;
  logic                w_at_notch1, w_at_notch2, w_at_notch3;
  logic                w_unused_notch;
  logic                w_key_ok;
  logic                w_idle_ready;
  logic                w_stage;
  logic [1:0]          w_sel;
  logic                w_dir;
  logic [LETTER_W-1:0] w_rot;

  enigma_rotor_stepper #(
    .NOTCH1 (NOTCH1),
    .NOTCH2 (NOTCH2),
    .NOTCH3 (NOTCH3)
  ) u_stepper (
    .i_pos1      (r_pos1),
    .i_pos2      (r_pos2),
    .i_pos3      (r_pos3),
    .o_next1     (w_next1),
    .o_next2     (w_next2),
    .o_next3     (w_next3),
    .o_at_notch1 (w_at_notch1),
    .o_at_notch2 (w_at_notch2),
    .o_at_notch3 (w_at_notch3)
  );

  assign w_unused_notch = w_at_notch1 & w_at_notch2;
  assign w_key_ok       = (key_in != '0) && (key_in <= LETTER_W'(NUM_LETTERS));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode plus per-stage datapath select, direction and rotor.
  always_comb begin
    w_state_nxt  = r_state;
    w_idle_ready = 1'b0;
    w_stage      = 1'b0;
    w_sel        = SEL_R1;
    w_dir        = 1'b0;
    w_rot        = '0;
    unique case (r_state)
      IDLE: begin
        w_idle_ready = ~cfg_we;
        if (key_valid && !cfg_we && w_key_ok) w_state_nxt = STEP;
      end
      STEP: w_state_nxt = F1;
      F1: begin
        w_stage = 1'b1; w_sel = SEL_R1; w_rot = r_pos1; w_state_nxt = F2;
      end
      F2: begin
        w_stage = 1'b1; w_sel = SEL_R2; w_rot = r_pos2; w_state_nxt = F3;
      end
      F3: begin
        w_stage = 1'b1; w_sel = SEL_R3; w_rot = r_pos3; w_state_nxt = RF;
      end
      RF: begin
        w_stage = 1'b1; w_sel = SEL_REFL; w_state_nxt = B3;
      end
      B3: begin
        w_stage = 1'b1; w_sel = SEL_R3; w_dir = 1'b1; w_rot = r_pos3; w_state_nxt = B2;
      end
      B2: begin
        w_stage = 1'b1; w_sel = SEL_R2; w_dir = 1'b1; w_rot = r_pos2; w_state_nxt = B1;
      end
      B1: begin
        w_stage = 1'b1; w_sel = SEL_R1; w_dir = 1'b1; w_rot = r_pos1; w_state_nxt = HOLD;
      end
      HOLD: if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_stage && (path_out == '0)) w_state_nxt = IDLE;
  end

  // Rotor positions, letter pipeline register, held output and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos1   <= '0;
      r_pos2   <= '0;
      r_pos3   <= '0;
      r_letter <= '0;
      r_out    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (r_state == IDLE) begin
        if (cfg_we) begin
          r_pos1 <= pos_norm(cfg_pos1);
          r_pos2 <= pos_norm(cfg_pos2);
          r_pos3 <= pos_norm(cfg_pos3);
        end else if (key_valid) begin
          if (w_key_ok) r_letter <= key_in;
          else          r_err    <= 1'b1;
        end
      end
      if (r_state == STEP) begin
        r_pos1 <= w_next1;
        r_pos2 <= w_next2;
        r_pos3 <= w_next3;
      end
      if (w_stage) begin
        if (path_out == '0) begin
          r_err <= 1'b1;
        end else begin
          r_letter <= path_out;
          if (r_state == B1) r_out <= path_out;
        end
      end
    end
  end

  assign key_ready  = rst_n & w_idle_ready;
  assign out_valid  = (r_state == HOLD);
  assign out_letter = r_out;
  assign err        = r_err;
  assign pos1       = r_pos1;
  assign pos2       = r_pos2;
  assign pos3       = r_pos3;
  assign at_notch3  = w_at_notch3;
  assign path_sel   = w_sel;
  assign path_dir   = w_dir;
  assign path_rot   = w_rot;
  assign path_in    = w_stage ? r_letter : '0;

endmodule

// File: tb/tb_enigma_rotor_sched.sv
// Bench for enigma_rotor_sched: directed keys with hand-computed letters and
// positions, scoreboard queue checked by an independent output monitor.
module tb_enigma_rotor_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [4:0] cfg_pos1 = '0, cfg_pos2 = '0, cfg_pos3 = '0;
  logic       key_valid = 1'b0;
  logic       key_ready;
  logic [4:0] key_in = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [4:0] out_letter;
  logic       err;
  logic [4:0] pos1, pos2, pos3;
  logic       at_notch3;
  logic [1:0] path_sel;
  logic       path_dir;
  logic [4:0] path_rot;
  logic [4:0] path_in;
  logic [4:0] path_out;

  int total = 0;
  int bad   = 0;
  int mode  = 0;  // 0 identity, 1 +1 per stage, 2 reflector returns 0

  typedef struct {
    logic [4:0] letter;
    logic [4:0] p1, p2, p3;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  enigma_rotor_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_pos1   (cfg_pos1),
    .cfg_pos2   (cfg_pos2),
    .cfg_pos3   (cfg_pos3),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_in     (key_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_letter (out_letter),
    .err        (err),
    .pos1       (pos1),
    .pos2       (pos2),
    .pos3       (pos3),
    .at_notch3  (at_notch3),
    .path_sel   (path_sel),
    .path_dir   (path_dir),
    .path_rot   (path_rot),
    .path_in    (path_in),
    .path_out   (path_out)
  );

  function automatic logic [4:0] inc26(input logic [4:0] v);
    return (v == 5'd26) ? 5'd1 : v + 5'd1;
  endfunction

  // External substitution datapath model.
  always_comb begin
    case (mode)
      1:       path_out = inc26(path_in);
      2:       path_out = (path_sel == 2'd3) ? 5'd0 : path_in;
      default: path_out = path_in;
    endcase
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_pos(input string nm, input logic [4:0] e1, e2, e3);
    check({nm, "_pos1"}, pos1, e1);
    check({nm, "_pos2"}, pos2, e2);
    check({nm, "_pos3"}, pos3, e3);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!key_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!key_ready) check("key_ready_timeout", key_ready, 1);
  endtask

  task automatic set_cfg(input logic [4:0] a, b, c);
    @(negedge clk);
    cfg_we = 1'b1; cfg_pos1 = a; cfg_pos2 = b; cfg_pos3 = c;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  // Valid key: push expectation, then check the stage sequence and latency.
  task automatic send_key(input logic [4:0] k, exp_l, e1, e2, e3);
    logic [4:0] rots[7];
    logic [1:0] sels[7];
    logic       dirs[7];
    logic [4:0] lin;
    exp_t       e;
    rots = '{e1, e2, e3, 5'd0, e3, e2, e1};
    sels = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
    dirs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    wait_ready();
    key_in = k; key_valid = 1'b1;
    e.letter = exp_l; e.p1 = e1; e.p2 = e2; e.p3 = e3;
    sb.push_back(e);
    @(posedge clk);
    #1 key_valid = 1'b0; key_in = '0;
    @(negedge clk);
    check("step_key_ready", key_ready, 0);
    lin = k;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      check($sformatf("stage%0d_sel", j), path_sel, sels[j]);
      check($sformatf("stage%0d_dir", j), path_dir, dirs[j]);
      check($sformatf("stage%0d_rot", j), path_rot, rots[j]);
      check($sformatf("stage%0d_in", j), path_in, lin);
      check($sformatf("stage%0d_out_valid", j), out_valid, 0);
      if (mode == 1) lin = inc26(lin);
    end
    @(negedge clk);
    check("latency_out_valid", out_valid, 1);
  endtask

  task automatic send_bad(input logic [4:0] k, e1, e2, e3);
    wait_ready();
    key_in = k; key_valid = 1'b1;
    @(posedge clk);
    #1 key_valid = 1'b0; key_in = '0;
    @(negedge clk);
    check("bad_err_pulse", err, 1);
    check("bad_stays_idle", key_ready, 1);
    check_pos("bad", e1, e2, e3);
    @(negedge clk);
    check("bad_err_clear", err, 0);
    check("bad_no_out", out_valid, 0);
  endtask

  // Output monitor: pops the scoreboard on every output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("out_valid_unexpected", out_valid, 0);
        end else begin
          e = sb.pop_front();
          check("mon_letter", out_letter, e.letter);
          check_pos("mon", e.p1, e.p2, e.p3);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset values
    #3;
    check("rst_key_ready", key_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_letter", out_letter, 0);
    check("rst_err", err, 0);
    check_pos("rst", 0, 0, 0);
    check("rst_path", {path_sel, path_dir, path_rot, path_in}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_rst_key_ready", key_ready, 1);

    // Identity datapath, stepping and wrap cases
    send_key(5'd1, 5'd1, 5'd1, 5'd0, 5'd0);
    set_cfg(5'd16, 5'd0, 5'd0);
    send_key(5'd5, 5'd5, 5'd17, 5'd1, 5'd0);
    set_cfg(5'd17, 5'd4, 5'd0);
    send_key(5'd1, 5'd1, 5'd18, 5'd5, 5'd1);
    set_cfg(5'd25, 5'd25, 5'd25);
    send_key(5'd3, 5'd3, 5'd0, 5'd25, 5'd25);
    set_cfg(5'd16, 5'd25, 5'd25);
    send_key(5'd26, 5'd26, 5'd17, 5'd0, 5'd25);

    // Shifting datapath: checks letter chaining between stages
    mode = 1;
    set_cfg(5'd0, 5'd0, 5'd0);
    send_key(5'd1, 5'd8, 5'd1, 5'd0, 5'd0);
    send_key(5'd25, 5'd6, 5'd2, 5'd0, 5'd0);

    // Invalid keys
    send_bad(5'd0, 5'd2, 5'd0, 5'd0);
    send_bad(5'd27, 5'd2, 5'd0, 5'd0);
    send_bad(5'd31, 5'd2, 5'd0, 5'd0);

    // Datapath returns 0 at the reflector: abort with err, no output
    mode = 2;
    wait_ready();
    key_in = 5'd4; key_valid = 1'b1;
    @(posedge clk);
    #1 key_valid = 1'b0; key_in = '0;
    repeat (5) @(negedge clk);
    check("abort_err_early", err, 0);
    @(negedge clk);
    check("abort_err_pulse", err, 1);
    check("abort_idle", key_ready, 1);
    check_pos("abort", 5'd3, 5'd0, 5'd0);
    @(negedge clk);
    check("abort_err_clear", err, 0);
    check("abort_no_out", out_valid, 0);

    // Consumer stalls for 20 cycles
    mode = 0;
    out_ready = 1'b0;
    send_key(5'd2, 5'd2, 5'd4, 5'd0, 5'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_letter", out_letter, 5'd2);
      check("hold_key_ready", key_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;

    // cfg_we and key_valid together: cfg wins
    wait_ready();
    cfg_we = 1'b1; cfg_pos1 = 5'd7; cfg_pos2 = 5'd8; cfg_pos3 = 5'd9;
    key_valid = 1'b1; key_in = 5'd1;
    #1 check("cfg_blocks_ready", key_ready, 0);
    @(posedge clk);
    #1 cfg_we = 1'b0; key_valid = 1'b0; key_in = '0;
    @(negedge clk);
    check_pos("cfg_key", 5'd7, 5'd8, 5'd9);
    check("cfg_key_err", err, 0);
    check("cfg_key_idle", key_ready, 1);
    repeat (12) @(negedge clk);
    check("cfg_key_still_idle", key_ready, 1);

    // Out-of-range cfg folding and notch3 flag
    set_cfg(5'd30, 5'd30, 5'd30);
    @(negedge clk);
    check_pos("cfg30", 5'd4, 5'd4, 5'd4);
    check("notch3_off", at_notch3, 0);
    set_cfg(5'd0, 5'd0, 5'd21);
    @(negedge clk);
    check("notch3_on", at_notch3, 1);

    // Reset asserted during B2
    wait_ready();
    key_in = 5'd1; key_valid = 1'b1;
    @(posedge clk);
    #1 key_valid = 1'b0; key_in = '0;
    repeat (7) @(negedge clk);
    check("b2_sel", path_sel, 2'd1);
    check("b2_dir", path_dir, 1);
    rst_n = 1'b0;
    #1;
    check_pos("midrst", 0, 0, 0);
    check("midrst_path", {path_sel, path_dir, path_rot, path_in}, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_key_ready", key_ready, 0);
    check("midrst_notch3", at_notch3, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_out", out_valid, 0);

    send_key(5'd1, 5'd1, 5'd1, 5'd0, 5'd0);
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
